scene_scheduler: RTL and testbench
==================================

Name: scene_scheduler

Overview:
- Frame-synchronous scheduler for scene-change events in the demoscene.
- Accepts event strobes from the edge-decoding front end and queues them in a small FIFO.
- Enforces a minimum on-screen dwell per scene.
- Sequences each change as fade-out, scene swap, fade-in, with all updates aligned to frame_start (vblank). The renderer consumes scene and fade_level.

Parameters:
- DEPTH, 4, event FIFO entries (power of two, ≥2).
- NUM_SCENES, 9, valid scene ids 0..NUM_SCENES-1.
- DWELL_FRAMES, 30, minimum frames a scene is shown at full brightness before the next change.
- FADE_STEP, 1, fade_level change per frame during transitions (1..15).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- ev_valid  input  1  single-cycle event strobe
- ev_num  input  4  requested scene id, qualified by ev_valid
- frame_start  input  1  single-cycle pulse once per frame at start of vblank
- scene  output  4  currently displayed scene id
- fade_level  output  4  brightness: 15 = full, 0 = black
- transition  output  1  high while state ≠ SHOW
- scene_changed  output  1  one-cycle pulse on the cycle scene updates
- queue_full  output  1  FIFO holds DEPTH entries
- drop_count  output  8  count of events dropped for full queue, saturating at 255

Behaviour:
- Reset (reset=0 at a clk edge) is synchronous, active-low and has priority over everything, including mid-transition:
  - scene=0, fade_level=15, transition=0, scene_changed=0, queue_full=0, drop_count=0.
  - FIFO is emptied and state=SHOW.
  - dwell_cnt=DWELL_FRAMES, so the first queued event may start a change at the next frame_start.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Enqueue filtering, evaluated when ev_valid=1:
  - ev_num ≥ NUM_SCENES: ignored; no drop count.
  - ev_num equals the most recently enqueued entry still in the FIFO: coalesced (ignored).
  - FIFO empty, state=SHOW and ev_num==scene: ignored.
  - Otherwise the event is written. It is visible in FIFO status on the next cycle.
- FIFO full and no pop in the same cycle: the event is dropped and drop_count increments, saturating at 255.
- Push and pop in the same cycle are both honoured, including when the FIFO is full. Occupancy is unchanged in that case and nothing is dropped.
- Pointers wrap modulo DEPTH. queue_full is derived from an occupancy counter of width log2(DEPTH)+1.
- dwell_cnt increments on each frame_start while in SHOW, saturating at DWELL_FRAMES.
- FSM SHOW:
  - Transitions on frame_start when dwell_cnt ≥ DWELL_FRAMES and the FIFO is non-empty.
  - On that transition: pop the head into next_scene, go to FADE_OUT, fade_level unchanged.
  - Otherwise stay in SHOW.
- FSM FADE_OUT, on each frame_start:
  - If fade_level ≤ FADE_STEP: fade_level=0, scene=next_scene, pulse scene_changed, go to FADE_IN.
  - Else fade_level -= FADE_STEP.
- FSM FADE_IN, on each frame_start:
  - If fade_level ≥ 15-FADE_STEP: fade_level=15, dwell_cnt=0, go to SHOW.
  - Else fade_level += FADE_STEP.
- transition=1 in FADE_OUT and FADE_IN.
- Events arriving during FADE_OUT/FADE_IN are queued normally and never abort the transition in progress. They are applied in order after their dwell.
- ev_valid coincident with a frame_start that pops the FIFO: the pop uses pre-push contents. The new entry lands behind any remaining entries.
- frame_start with no pending work has no effect beyond advancing dwell_cnt.
- Timing with FADE_STEP=1, frames counted from the popping frame_start F0:
  - fade_level = 14 at F1 … 1 at F14, then 0 at F15 together with the scene swap.
  - fade_level rises 1 at F16 … 14 at F29, then 15 and SHOW at F30.

Test Plan:
- Reset, then ev_num=3 strobe, then frame_start pulses:
  - F0 pops and sets transition=1.
  - scene=3 and a one-cycle scene_changed pulse at F15.
  - fade_level=15, transition=0 at F30.
- ev_num=0 while scene=0 with empty FIFO, ev_num=9, and ev_num=5 twice back-to-back: only one entry (5) is enqueued and drop_count stays 0.
- DEPTH=4: during a transition enqueue 1,2,4,6, then 7 → queue_full=1 and drop_count=1. Queue order 1,2,4,6 is then applied sequentially, each change separated by ≥DWELL_FRAMES full-brightness frames.
- FIFO full and ev_valid on the same cycle as a popping frame_start: new event accepted, queue_full remains 1, drop_count unchanged.
- Assert reset=0 for one cycle at fade_level=7 in FADE_OUT: next cycle scene=0, fade_level=15, transition=0, queue empty, drop_count=0.
- FADE_STEP=4, DWELL_FRAMES=2: the fade sequence is 15,11,7,3 then 0 with the swap, then 4,8,12,15. The next queued change waits exactly 2 frame_starts in SHOW.

Source files
------------

// File: rtl/scene_scheduler.sv
// Frame-synchronous scene-change scheduler: queues scene requests, enforces a dwell
// at full brightness, and sequences fade-out / swap / fade-in on frame_start.
module scene_scheduler #(
    parameter int DEPTH        = 4,
    parameter int NUM_SCENES   = 9,
    parameter int DWELL_FRAMES = 30,
    parameter int FADE_STEP    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ev_valid,
    input  logic [3:0] ev_num,
    input  logic       frame_start,
    output logic [3:0] scene,
    output logic [3:0] fade_level,
    output logic       transition,
    output logic       scene_changed,
    output logic       queue_full,
    output logic [7:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DWELL_FRAMES + 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES);
    localparam logic [3:0]    STEP      = 4'(FADE_STEP);
    localparam logic [3:0]    BRIGHT    = 4'd15;

    typedef enum logic [1:0] {SHOW, FADE_OUT, FADE_IN} state_t;

    state_t        r_state, w_state_next;
    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr, w_tail_ptr;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_dwell, w_dwell_next;
    logic [3:0]    r_fade, w_fade_next;
    logic [3:0]    r_scene, w_scene_next;
    logic [3:0]    r_next_scene, w_next_scene_next;
    logic          r_changed, w_changed_next;
    logic          r_transition;
    logic [7:0]    r_drop;
    logic          w_empty, w_full, w_pop, w_want, w_push, w_drop;

    assign w_tail_ptr = r_wptr - AW'(1);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = frame_start && (r_state == SHOW) && (r_dwell >= DWELL_MAX) && !w_empty;

    // Filter order: out-of-range id, repeat of the newest queued entry, request for the scene already idle on screen.
    assign w_want = ev_valid
                 && ({1'b0, ev_num} < 5'(NUM_SCENES))
                 && !(!w_empty && (ev_num == r_mem[w_tail_ptr]))
                 && !(w_empty && (r_state == SHOW) && (ev_num == r_scene));
    assign w_push = w_want && (!w_full || w_pop);
    assign w_drop = w_want && w_full && !w_pop;

    // NOTE: the storage array has no reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= ev_num;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
        end
    end

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_next      = r_state;
        w_dwell_next      = r_dwell;
        w_fade_next       = r_fade;
        w_scene_next      = r_scene;
        w_next_scene_next = r_next_scene;
        w_changed_next    = 1'b0;
        case (r_state)
            SHOW: begin
                if (frame_start) begin
                    if (r_dwell < DWELL_MAX) w_dwell_next = r_dwell + DW'(1);
                    if (w_pop) begin
                        w_next_scene_next = r_mem[r_rptr];
                        w_state_next      = FADE_OUT;
                    end
                end
            end
            FADE_OUT: begin
                if (frame_start) begin
                    if (r_fade <= STEP) begin
                        w_fade_next    = '0;
                        w_scene_next   = r_next_scene;
                        w_changed_next = 1'b1;
                        w_state_next   = FADE_IN;
                    end else begin
                        w_fade_next = r_fade - STEP;
                    end
                end
            end
            FADE_IN: begin
                if (frame_start) begin
                    if (r_fade >= BRIGHT - STEP) begin
                        w_fade_next  = BRIGHT;
                        w_dwell_next = '0;
                        w_state_next = SHOW;
                    end else begin
                        w_fade_next = r_fade + STEP;
                    end
                end
            end
            default: w_state_next = SHOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= SHOW;
            r_dwell      <= DWELL_MAX;
            r_fade       <= BRIGHT;
            r_scene      <= '0;
            r_next_scene <= '0;
            r_changed    <= 1'b0;
            r_transition <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_dwell      <= w_dwell_next;
            r_fade       <= w_fade_next;
            r_scene      <= w_scene_next;
            r_next_scene <= w_next_scene_next;
            r_changed    <= w_changed_next;
            r_transition <= (w_state_next != SHOW);
        end
    end

    assign scene         = r_scene;
    assign fade_level    = r_fade;
    assign transition    = r_transition;
    assign scene_changed = r_changed;
    assign queue_full    = r_count[AW];
    assign drop_count    = r_drop;

endmodule

// File: tb/tb_scene_scheduler.sv
// Directed bench for scene_scheduler: default instance plus a fast instance
// (DWELL_FRAMES=2, FADE_STEP=4) for the coarse-fade and short-dwell timing.
module tb_scene_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ev_valid, frame_start;
    logic [3:0] ev_num;
    logic [3:0] scene, fade_level;
    logic       transition, scene_changed, queue_full;
    logic [7:0] drop_count;

    logic       reset_b, ev_valid_b, frame_start_b;
    logic [3:0] ev_num_b;
    logic [3:0] scene_b, fade_level_b;
    logic       transition_b, scene_changed_b, queue_full_b;
    logic [7:0] drop_count_b;

    int n_checks = 0;
    int n_pass   = 0;

    scene_scheduler dut (
        .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_num(ev_num),
        .frame_start(frame_start), .scene(scene), .fade_level(fade_level),
        .transition(transition), .scene_changed(scene_changed),
        .queue_full(queue_full), .drop_count(drop_count)
    );

    scene_scheduler #(.DEPTH(4), .NUM_SCENES(9), .DWELL_FRAMES(2), .FADE_STEP(4)) dut_fast (
        .clk(clk), .reset(reset_b), .ev_valid(ev_valid_b), .ev_num(ev_num_b),
        .frame_start(frame_start_b), .scene(scene_b), .fade_level(fade_level_b),
        .transition(transition_b), .scene_changed(scene_changed_b),
        .queue_full(queue_full_b), .drop_count(drop_count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    // Inputs change on the falling edge; outputs are read on the falling edge after the active edge.
    task automatic pulse_frame(input bit fast);
        @(negedge clk);
        if (fast) frame_start_b = 1'b1;
        else      frame_start   = 1'b1;
        @(negedge clk);
        frame_start   = 1'b0;
        frame_start_b = 1'b0;
    endtask

    task automatic send_ev(input bit fast, input logic [3:0] n);
        @(negedge clk);
        if (fast) begin ev_valid_b = 1'b1; ev_num_b = n; end
        else      begin ev_valid   = 1'b1; ev_num   = n; end
        @(negedge clk);
        ev_valid   = 1'b0;
        ev_valid_b = 1'b0;
    endtask

    task automatic do_reset(input bit fast);
        @(negedge clk);
        if (fast) reset_b = 1'b0;
        else      reset   = 1'b0;
        @(negedge clk);
        reset   = 1'b1;
        reset_b = 1'b1;
    endtask

    task automatic wait_change(input int limit, output int frames, output bit seen);
        frames = 0;
        seen   = 1'b0;
        while (!seen && frames < limit) begin
            pulse_frame(1'b0);
            frames++;
            if (scene_changed) seen = 1'b1;
        end
    endtask

    initial begin
        int         frames;
        bit         seen;
        logic [3:0] order [4]   = '{4'd1, 4'd2, 4'd4, 4'd6};
        logic [3:0] fast_fade [8] = '{4'd11, 4'd7, 4'd3, 4'd0, 4'd4, 4'd8, 4'd12, 4'd15};

        reset = 1'b0; ev_valid = 1'b0; ev_num = '0; frame_start = 1'b0;
        reset_b = 1'b0; ev_valid_b = 1'b0; ev_num_b = '0; frame_start_b = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1; reset_b = 1'b1;
        @(negedge clk);

        check("rst_scene", scene, 0);
        check("rst_fade", fade_level, 15);
        check("rst_transition", transition, 0);
        check("rst_changed", scene_changed, 0);
        check("rst_full", queue_full, 0);
        check("rst_drops", drop_count, 0);

        // Basic change to scene 3 with single-step fades.
        send_ev(1'b0, 4'd3);
        pulse_frame(1'b0);
        check("f0_transition", transition, 1);
        check("f0_fade", fade_level, 15);
        for (int i = 1; i <= 14; i++) begin
            pulse_frame(1'b0);
            check("fade_out", fade_level, 32'(15 - i));
        end
        check("pre_swap_scene", scene, 0);
        pulse_frame(1'b0);
        check("f15_scene", scene, 3);
        check("f15_fade", fade_level, 0);
        check("f15_changed", scene_changed, 1);
        @(negedge clk);
        check("changed_one_cycle", scene_changed, 0);
        for (int i = 16; i <= 29; i++) begin
            pulse_frame(1'b0);
            check("fade_in", fade_level, 32'(i - 15));
        end
        check("f29_transition", transition, 1);
        pulse_frame(1'b0);
        check("f30_fade", fade_level, 15);
        check("f30_transition", transition, 0);

        // Filtering, fill, drop and push-with-pop on a full queue.
        do_reset(1'b0);
        send_ev(1'b0, 4'd0);
        send_ev(1'b0, 4'd9);
        @(negedge clk); ev_valid = 1'b1; ev_num = 4'd5;
        @(negedge clk);
        @(negedge clk); ev_valid = 1'b0;
        check("filter_full", queue_full, 0);
        check("filter_drops", drop_count, 0);
        send_ev(1'b0, 4'd1);
        send_ev(1'b0, 4'd2);
        check("three_not_full", queue_full, 0);
        send_ev(1'b0, 4'd4);
        check("four_full", queue_full, 1);
        check("four_drops", drop_count, 0);
        send_ev(1'b0, 4'd7);
        check("overflow_drops", drop_count, 1);
        check("overflow_full", queue_full, 1);
        check("no_frame_scene", scene, 0);
        @(negedge clk); frame_start = 1'b1; ev_valid = 1'b1; ev_num = 4'd6;
        @(negedge clk); frame_start = 1'b0; ev_valid = 1'b0;
        check("pushpop_transition", transition, 1);
        check("pushpop_full", queue_full, 1);
        check("pushpop_drops", drop_count, 1);

        wait_change(40, frames, seen);
        check("first_seen", seen, 1);
        check("first_scene", scene, 5);
        check("first_frames", frames, 15);
        for (int k = 0; k < 4; k++) begin
            wait_change(100, frames, seen);
            check("seq_seen", seen, 1);
            check("seq_scene", scene, order[k]);
            check("seq_spacing", frames, 61);
        end
        wait_change(100, frames, seen);
        check("queue_drained", seen, 0);
        check("final_drops", drop_count, 1);

        // Reset mid fade-out with a full queue and a nonzero drop count.
        do_reset(1'b0);
        send_ev(1'b0, 4'd3);
        pulse_frame(1'b0);
        for (int i = 1; i <= 8; i++) pulse_frame(1'b0);
        send_ev(1'b0, 4'd1);
        send_ev(1'b0, 4'd2);
        send_ev(1'b0, 4'd4);
        send_ev(1'b0, 4'd6);
        send_ev(1'b0, 4'd7);
        check("mid_fade", fade_level, 7);
        check("mid_transition", transition, 1);
        check("mid_drops", drop_count, 1);
        do_reset(1'b0);
        check("mid_rst_scene", scene, 0);
        check("mid_rst_fade", fade_level, 15);
        check("mid_rst_transition", transition, 0);
        check("mid_rst_full", queue_full, 0);
        check("mid_rst_drops", drop_count, 0);
        pulse_frame(1'b0);
        check("mid_rst_queue_empty", transition, 0);

        // Coarse fade and two-frame dwell on the fast instance.
        send_ev(1'b1, 4'd5);
        send_ev(1'b1, 4'd7);
        pulse_frame(1'b1);
        check("fast_f0_transition", transition_b, 1);
        check("fast_f0_fade", fade_level_b, 15);
        for (int i = 0; i < 8; i++) begin
            pulse_frame(1'b1);
            check("fast_fade", fade_level_b, fast_fade[i]);
            if (i == 3) begin
                check("fast_swap_scene", scene_b, 5);
                check("fast_swap_changed", scene_changed_b, 1);
            end
        end
        check("fast_show", transition_b, 0);
        pulse_frame(1'b1);
        check("fast_dwell1", transition_b, 0);
        pulse_frame(1'b1);
        check("fast_dwell2", transition_b, 0);
        pulse_frame(1'b1);
        check("fast_next_pop", transition_b, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
